// File: rtl/wb_arb_pkg.sv
// Shared types for the CDB writeback arbiter: FSM states and the held FU result.
// Sizes mirror the arbiter's default parameters.
package wb_arb_pkg;

  localparam int WB_NUM_FU       = 4;
  localparam int WB_INST_ID_BITS = 6;
  localparam int WB_PRN_BITS     = 6;
  localparam int WB_MAX_OPERANDS = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [WB_INST_ID_BITS-1:0]                   inst_id;
    logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]  prn;
    logic [WB_MAX_OPERANDS-1:0][63:0]             data;
    logic [WB_MAX_OPERANDS-1:0]                   data_valid;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
// Zero latency; the search wraps modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      idx = PW'((int'(ptr) + o) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Round-robin FU results into a one-entry holder, then one CDB beat per valid dest per cycle;
// the next result is taken on the last-emit cycle. Optional counters under WB_ARB_PERF_EN.
module wb_cdb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_FU       = WB_NUM_FU,
  parameter int INST_ID_BITS = WB_INST_ID_BITS,
  parameter int PRN_BITS     = WB_PRN_BITS,
  parameter int MAX_OPERANDS = WB_MAX_OPERANDS
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_FU-1:0]                              fu_valid,
  output logic [NUM_FU-1:0]                              fu_ready,
  input  logic [NUM_FU-1:0][INST_ID_BITS-1:0]            fu_inst_id,
  input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_prn,
  input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]      fu_data,
  input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0]            fu_data_valid,
  output logic                                           cdb_valid,
  output logic [PRN_BITS-1:0]                            cdb_prn,
  output logic [63:0]                                    cdb_value,
  output logic                                           done_valid,
  output logic [INST_ID_BITS-1:0]                        done_inst_id,
  output logic [31:0]                                    perf_grants,
  output logic [31:0]                                    perf_stalls
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int KW = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1;

  wb_state_e               state_q, state_d;
  logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [MAX_OPERANDS-1:0] sent_q, sent_d;
  wb_req_t                 req_q, req_d;

  logic [NUM_FU-1:0]       grant;
  logic [PW-1:0]           grant_idx;
  logic [MAX_OPERANDS-1:0] pending, emit_oh;
  logic [KW-1:0]           emit_idx;
  logic                    drain, last_emit, can_accept, accept;

  rr_arbiter #(.N(NUM_FU)) u_rr (
    .req   (fu_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  assign drain   = (state_q == DRAIN);
  assign pending = req_q.data_valid & ~sent_q;

  // Lowest unsent valid slot wins, so duplicate PRNs go out in slot order.
  always_comb begin
    emit_oh  = '0;
    emit_idx = '0;
    for (int k = MAX_OPERANDS - 1; k >= 0; k--) begin
      if (pending[k]) begin
        emit_oh  = MAX_OPERANDS'(1) << k;
        emit_idx = KW'(k);
      end
    end
  end

  assign last_emit  = drain && ((pending & ~emit_oh) == '0);
  assign can_accept = !drain || last_emit;
  assign accept     = !rst && can_accept && (|fu_valid);
  assign fu_ready   = (!rst && can_accept) ? grant : '0;

  assign cdb_valid    = !rst && drain && (|pending);
  assign cdb_prn      = cdb_valid ? req_q.prn[emit_idx] : '0;
  assign cdb_value    = cdb_valid ? req_q.data[emit_idx] : '0;
  assign done_valid   = !rst && last_emit;
  assign done_inst_id = done_valid ? req_q.inst_id : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sent_d   = sent_q;
    req_d    = req_q;
    if (drain) begin
      sent_d = sent_q | emit_oh;
      if (last_emit) begin
        state_d = IDLE;
        sent_d  = '0;
      end
    end
    if (accept) begin
      state_d          = DRAIN;
      sent_d           = '0;
      rr_ptr_d         = (int'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + PW'(1);
      req_d.inst_id    = fu_inst_id[grant_idx];
      req_d.prn        = fu_prn[grant_idx];
      req_d.data       = fu_data[grant_idx];
      req_d.data_valid = fu_data_valid[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      sent_q   <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sent_q   <= sent_d;
      req_q    <= req_d;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic        stall;

  assign stall = |(fu_valid & ~fu_ready);

  always_comb begin
    perf_grants_d = perf_grants_q;
    perf_stalls_d = perf_stalls_q;
    if (accept && (perf_grants_q != '1)) perf_grants_d = perf_grants_q + 32'd1;
    if (stall && (perf_stalls_q != '1)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_grants_q <= perf_grants_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Directed bench for wb_cdb_arbiter: inputs change 1ns after posedge, outputs are checked at negedge.
module tb_wb_cdb_arbiter;

`ifdef WB_ARB_PERF_EN
  localparam logic [31:0] EXP_GRANTS = 32'd5;
  localparam logic [31:0] EXP_STALLS = 32'd3;
`else
  localparam logic [31:0] EXP_GRANTS = 32'd0;
  localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic [3:0]                 fu_valid;
  logic [3:0]                 fu_ready;
  logic [3:0][5:0]            fu_inst_id;
  logic [3:0][2:0][5:0]       fu_prn;
  logic [3:0][2:0][63:0]      fu_data;
  logic [3:0][2:0]            fu_data_valid;
  logic                       cdb_valid;
  logic [5:0]                 cdb_prn;
  logic [63:0]                cdb_value;
  logic                       done_valid;
  logic [5:0]                 done_inst_id;
  logic [31:0]                perf_grants;
  logic [31:0]                perf_stalls;

  int tests = 0;
  int fails = 0;

  wb_cdb_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .fu_valid      (fu_valid),
    .fu_ready      (fu_ready),
    .fu_inst_id    (fu_inst_id),
    .fu_prn        (fu_prn),
    .fu_data       (fu_data),
    .fu_data_valid (fu_data_valid),
    .cdb_valid     (cdb_valid),
    .cdb_prn       (cdb_prn),
    .cdb_value     (cdb_value),
    .done_valid    (done_valid),
    .done_inst_id  (done_inst_id),
    .perf_grants   (perf_grants),
    .perf_stalls   (perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fu;
    fu_valid      = '0;
    fu_inst_id    = '0;
    fu_prn        = '0;
    fu_data       = '0;
    fu_data_valid = '0;
  endtask

  task automatic load_fu(input logic [1:0] i, input logic [5:0] id, input logic [2:0] dv,
                         input logic [5:0] p0, input logic [63:0] d0,
                         input logic [5:0] p1, input logic [63:0] d1,
                         input logic [5:0] p2, input logic [63:0] d2);
    fu_valid[i]      = 1'b1;
    fu_inst_id[i]    = id;
    fu_data_valid[i] = dv;
    fu_prn[i][0]     = p0;
    fu_data[i][0]    = d0;
    fu_prn[i][1]     = p1;
    fu_data[i][1]    = d1;
    fu_prn[i][2]     = p2;
    fu_data[i][2]    = d2;
  endtask

  task automatic do_reset;
    tick;
    clear_fu();
    rst = 1'b1;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_fu();
    load_fu(2'd0, 6'd1, 3'b001, 6'd1, 64'h1, 6'd0, 64'h0, 6'd0, 64'h0);
    tick;
    @(negedge clk);
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL rst_cdb_valid: got %b expected 0", cdb_valid); end
    tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL rst_done_valid: got %b expected 0", done_valid); end
    tests++; if (fu_ready !== 4'b0000) begin fails++; $display("FAIL rst_fu_ready: got %b expected 0000", fu_ready); end
    tick;
    rst = 1'b0;
    @(negedge clk);
    tests++; if (fu_ready !== 4'b0001) begin fails++; $display("FAIL rst_first_ready: got %b expected 0001", fu_ready); end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id} !== {1'b1, 6'd1, 64'h1, 1'b1, 6'd1}) begin
      fails++; $display("FAIL rst_first_beat: got v=%b prn=%0d val=%h done=%b id=%0d expected 1 1 1 1 1",
                        cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id);
    end
    tick;
    @(negedge clk);
    tests++; if ({cdb_valid, done_valid} !== 2'b00) begin fails++; $display("FAIL rst_idle_after: got %b expected 00", {cdb_valid, done_valid}); end
  endtask

  task automatic test_single_dest;
    load_fu(2'd1, 6'd5, 3'b001, 6'd12, 64'hDEAD, 6'd0, 64'h0, 6'd0, 64'h0);
    @(negedge clk);
    tests++; if (fu_ready !== 4'b0010) begin fails++; $display("FAIL single_ready: got %b expected 0010", fu_ready); end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id} !== {1'b1, 6'd12, 64'hDEAD, 1'b1, 6'd5}) begin
      fails++; $display("FAIL single_beat: got v=%b prn=%0d val=%h done=%b id=%0d expected 1 12 dead 1 5",
                        cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id);
    end
    tick;
  endtask

  task automatic test_multi_dest;
    load_fu(2'd2, 6'd9, 3'b101, 6'd3, 64'h11, 6'd63, 64'hBAD, 6'd7, 64'h22);
    @(negedge clk);
    tests++; if (fu_ready !== 4'b0100) begin fails++; $display("FAIL multi_ready: got %b expected 0100", fu_ready); end
    tick;
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, cdb_value, done_valid} !== {1'b1, 6'd3, 64'h11, 1'b0}) begin
      fails++; $display("FAIL multi_beat1: got v=%b prn=%0d val=%h done=%b expected 1 3 11 0",
                        cdb_valid, cdb_prn, cdb_value, done_valid);
    end
    tests++; if (fu_ready !== 4'b0000) begin fails++; $display("FAIL multi_stall: got %b expected 0000", fu_ready); end
    tick;
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id} !== {1'b1, 6'd7, 64'h22, 1'b1, 6'd9}) begin
      fails++; $display("FAIL multi_beat2: got v=%b prn=%0d val=%h done=%b id=%0d expected 1 7 22 1 9",
                        cdb_valid, cdb_prn, cdb_value, done_valid, done_inst_id);
    end
    tests++; if (fu_ready !== 4'b0100) begin fails++; $display("FAIL multi_ready2: got %b expected 0100", fu_ready); end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, done_valid} !== {1'b1, 6'd3, 1'b0}) begin
      fails++; $display("FAIL multi_no_bubble: got v=%b prn=%0d done=%b expected 1 3 0", cdb_valid, cdb_prn, done_valid);
    end
    tick;
    tick;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_ready [5];
    exp_ready[0] = 4'b0001; exp_ready[1] = 4'b0010; exp_ready[2] = 4'b0100;
    exp_ready[3] = 4'b1000; exp_ready[4] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++)
      load_fu(2'(i), 6'(10 + i), 3'b001, 6'(20 + i), 64'(256 + i), 6'd0, 64'h0, 6'd0, 64'h0);
    for (int c = 0; c < 6; c++) begin
      if (c >= 1 && c <= 3) fu_valid[c-1] = 1'b0;
      if (c == 4) begin
        fu_valid[3] = 1'b0;
        load_fu(2'd0, 6'd14, 3'b001, 6'd24, 64'h104, 6'd0, 64'h0, 6'd0, 64'h0);
      end
      if (c == 5) clear_fu();
      @(negedge clk);
      if (c < 5) begin
        tests++;
        if (fu_ready !== exp_ready[c]) begin
          fails++; $display("FAIL fair_ready_c%0d: got %b expected %b", c, fu_ready, exp_ready[c]);
        end
      end
      if (c >= 1) begin
        tests++;
        if ({cdb_valid, cdb_prn, done_valid} !== {1'b1, 6'(19 + c), 1'b1}) begin
          fails++; $display("FAIL fair_beat_c%0d: got v=%b prn=%0d done=%b expected 1 %0d 1",
                            c, cdb_valid, cdb_prn, done_valid, 19 + c);
        end
      end
      tick;
    end
    @(negedge clk);
    tests++; if (perf_grants !== EXP_GRANTS) begin fails++; $display("FAIL perf_grants: got %0d expected %0d", perf_grants, EXP_GRANTS); end
    tests++; if (perf_stalls !== EXP_STALLS) begin fails++; $display("FAIL perf_stalls: got %0d expected %0d", perf_stalls, EXP_STALLS); end
    tick;
  endtask

  task automatic test_nodest_and_reset;
    load_fu(2'd3, 6'd2, 3'b000, 6'd0, 64'h0, 6'd0, 64'h0, 6'd0, 64'h0);
    @(negedge clk);
    tests++; if (fu_ready !== 4'b1000) begin fails++; $display("FAIL nodest_ready: got %b expected 1000", fu_ready); end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, done_valid, done_inst_id} !== {1'b0, 1'b1, 6'd2}) begin
      fails++; $display("FAIL nodest_done: got v=%b done=%b id=%0d expected 0 1 2", cdb_valid, done_valid, done_inst_id);
    end
    tick;
    @(negedge clk);
    tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL nodest_single: got done=%b expected 0", done_valid); end
    tick;
    load_fu(2'd1, 6'd7, 3'b111, 6'd1, 64'hA1, 6'd2, 64'hA2, 6'd3, 64'hA3);
    @(negedge clk);
    tests++; if (fu_ready !== 4'b0010) begin fails++; $display("FAIL rstmid_ready: got %b expected 0010", fu_ready); end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, done_valid} !== {1'b1, 6'd1, 1'b0}) begin
      fails++; $display("FAIL rstmid_beat1: got v=%b prn=%0d done=%b expected 1 1 0", cdb_valid, cdb_prn, done_valid);
    end
    tick;
    rst = 1'b1;
    @(negedge clk);
    tests++; if (done_valid !== 1'b0) begin fails++; $display("FAIL rstmid_done_in_rst: got %b expected 0", done_valid); end
    tick;
    rst = 1'b0;
    load_fu(2'd0, 6'd4, 3'b001, 6'd9, 64'h99, 6'd0, 64'h0, 6'd0, 64'h0);
    @(negedge clk);
    tests++;
    if ({fu_ready, cdb_valid, done_valid} !== {4'b0001, 1'b0, 1'b0}) begin
      fails++; $display("FAIL rstmid_idle: got ready=%b v=%b done=%b expected 0001 0 0", fu_ready, cdb_valid, done_valid);
    end
    tick;
    clear_fu();
    @(negedge clk);
    tests++;
    if ({cdb_valid, cdb_prn, done_valid, done_inst_id} !== {1'b1, 6'd9, 1'b1, 6'd4}) begin
      fails++; $display("FAIL rstmid_next: got v=%b prn=%0d done=%b id=%0d expected 1 9 1 4",
                        cdb_valid, cdb_prn, done_valid, done_inst_id);
    end
    tick;
  endtask

  initial begin
    test_reset();
    test_single_dest();
    test_multi_dest();
    test_fairness();
    test_nodest_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
